// File: rtl/dram_emu_pkg.sv
// Shared types and helpers for the multiplexed-address DRAM emulator.
package dram_emu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        ACC  = 2'd2,
        CBR  = 2'd3
    } state_e;

    function automatic int unsigned depth_f(input int unsigned aw);
        return 32'd1 << (2 * aw);
    endfunction

endpackage

// File: rtl/dram_emu_store.sv
// Read-first simple dual-port word store with a RD_LAT-deep output pipeline.
module dram_emu_store
    import dram_emu_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [2*AW-1:0] i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    input  logic [2*AW-1:0] i_raddr,
    output logic [DW-1:0]   o_rdata
);

    localparam int unsigned DEPTH = depth_f(AW);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd  [RD_LAT];

    // Non-blocking update gives old data on a same-address read/write clk.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rd[0] <= r_mem[i_raddr];
        end
    end

    for (genvar s = 1; s < RD_LAT; s++) begin : g_lat
        always_ff @(posedge clk) begin
            r_rd[s] <= r_rd[s-1];
        end
    end

    assign o_rdata = r_rd[RD_LAT-1];

endmodule

// File: rtl/dram_emu.sv
// RAS/CAS DRAM emulator: synchronised strobes drive a small FSM in front of block RAM.
module dram_emu
    import dram_emu_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RASn,
    input  logic          CASn,
    input  logic          Wn,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          Q_oe,
    output logic          ref_pulse,
    output logic          err
);

    logic [2:0] w_async;
    logic [2:0] w_lvl;
    logic [2:0] w_prev;

    assign w_async = {Wn, CASn, RASn};

    for (genvar b = 0; b < 3; b++) begin : g_sync
        logic [SYNC-1:0] r_chain;
        logic            r_edge;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_chain <= '1;
                r_edge  <= 1'b1;
            end else begin
                r_chain <= {r_chain[SYNC-2:0], w_async[b]};
                r_edge  <= r_chain[SYNC-1];
            end
        end
        assign w_lvl[b]  = r_chain[SYNC-1];
        assign w_prev[b] = r_edge;
    end

    logic w_ras_fall, w_ras_rise, w_cas_fall, w_cas_rise, w_wn_fall;
    logic w_cas_lvl, w_wn_lvl;

    assign w_ras_fall = w_prev[0] & ~w_lvl[0];
    assign w_ras_rise = ~w_prev[0] & w_lvl[0];
    assign w_cas_fall = w_prev[1] & ~w_lvl[1];
    assign w_cas_rise = ~w_prev[1] & w_lvl[1];
    assign w_wn_fall  = w_prev[2] & ~w_lvl[2];
    assign w_cas_lvl  = w_lvl[1];
    assign w_wn_lvl   = w_lvl[2];

    state_e            r_state, w_state;
    logic [AW-1:0]     r_row, r_col;
    logic              r_cas_seen, r_wrote;
    logic [RD_LAT-1:0] r_rp;
    logic              w_we, w_re, w_ref, w_err, w_load;
    logic [2*AW-1:0]   w_waddr, w_raddr;
    logic [DW-1:0]     w_rdata;

    always_comb begin
        w_state = r_state;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_ref   = 1'b0;
        w_err   = 1'b0;
        w_raddr = {r_row, A};
        w_waddr = {r_row, r_col};
        case (r_state)
            IDLE: begin
                if (w_ras_fall) begin
                    if (!w_cas_lvl) begin
                        w_state = CBR;
                        w_err   = w_cas_fall;
                    end else begin
                        w_state = ROW;
                    end
                end
            end
            ROW: begin
                if (w_ras_rise) begin
                    w_state = IDLE;
                    w_ref   = ~r_cas_seen;
                end else if (w_cas_fall) begin
                    w_state = ACC;
                    w_re    = 1'b1;
                    if (!w_wn_lvl) begin
                        w_we    = 1'b1;
                        w_waddr = {r_row, A};
                    end
                end
            end
            ACC: begin
                if (w_ras_rise) begin
                    w_state = IDLE;
                end else if (w_cas_rise) begin
                    w_state = ROW;
                end else if (w_wn_fall) begin
                    w_we = 1'b1;
                end
            end
            CBR: begin
                if (w_ras_rise) begin
                    w_state = IDLE;
                    w_ref   = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Read data only becomes visible for a pure-read access that is still open.
    assign w_load = r_rp[RD_LAT-1] & (r_state == ACC) & (w_state == ACC) & ~r_wrote & ~w_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_cas_seen <= 1'b0;
            r_wrote    <= 1'b0;
            r_rp       <= '0;
            Q          <= '0;
            Q_oe       <= 1'b0;
            ref_pulse  <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state   <= w_state;
            ref_pulse <= w_ref;
            err       <= w_err;
            r_rp      <= RD_LAT'({r_rp, w_re});
            if (r_state == IDLE && w_state == ROW) begin
                r_row      <= A;
                r_cas_seen <= 1'b0;
            end
            if (w_re) begin
                r_col      <= A;
                r_cas_seen <= 1'b1;
                r_wrote    <= ~w_wn_lvl;
            end else if (r_state == ACC && w_we) begin
                r_wrote <= 1'b1;
            end
            if (w_load) begin
                Q    <= w_rdata;
                Q_oe <= 1'b1;
            end else if (w_state != ACC) begin
                Q_oe <= 1'b0;
            end
        end
    end

    dram_emu_store #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_store (
        .clk     (clk),
        .i_we    (w_we & rst_n),
        .i_waddr (w_waddr),
        .i_wdata (D),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule
